// File: rtl/sdf_r2_stage_if.sv
// Port bundle of the SDF radix-2 stage: sample input, twiddle ROM port, and
// multiplier-facing operand output.
interface sdf_r2_stage_if #(
  parameter int N     = 64,
  parameter int WIDTH = 16
);
  localparam int AW = $clog2(N) - 1;

  logic                    di_en;
  logic signed [WIDTH-1:0] di_re;
  logic signed [WIDTH-1:0] di_im;
  logic [AW-1:0]           tw_addr;
  logic signed [WIDTH-1:0] tw_re;
  logic signed [WIDTH-1:0] tw_im;
  logic                    do_en;
  logic signed [WIDTH-1:0] do_re;
  logic signed [WIDTH-1:0] do_im;
  logic signed [WIDTH-1:0] do_tw_re;
  logic signed [WIDTH-1:0] do_tw_im;
  logic                    drop;

  modport master (
    output di_en, di_re, di_im, tw_re, tw_im,
    input  tw_addr, do_en, do_re, do_im, do_tw_re, do_tw_im, drop
  );

  modport slave (
    input  di_en, di_re, di_im, tw_re, tw_im,
    output tw_addr, do_en, do_re, do_im, do_tw_re, do_tw_im, drop
  );
endinterface

// File: rtl/sdf_r2_stage.sv
// Radix-2 DIF single-path delay-feedback stage: butterfly through an N/2 delay line,
// emitting data operand plus aligned twiddle for the following complex multiplier.
module sdf_r2_stage #(
  parameter int N     = 64,
  parameter int WIDTH = 16
) (
  input  logic          clock,
  input  logic          reset,
  sdf_r2_stage_if.slave bus
);
  localparam int M  = N / 2;
  localparam int AW = $clog2(N) - 1;
  localparam logic [AW-1:0] LAST = AW'(M - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FILL  = 2'd1;
  localparam logic [1:0] BFLY  = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  logic [1:0]              state, nxt_state;
  logic [AW-1:0]           cnt, nxt_cnt, addr;
  logic                    pend, nxt_pend;
  logic                    shift, emit, drop_nxt;
  logic signed [WIDTH-1:0] push_re, push_im, out_re, out_im;
  logic signed [WIDTH-1:0] dly_re [M];
  logic signed [WIDTH-1:0] dly_im [M];
  logic signed [WIDTH-1:0] x_re, x_im;
  logic signed [WIDTH:0]   sum_re, sum_im, dif_re, dif_im;
  logic                    do_en_q, drop_q;
  logic signed [WIDTH-1:0] do_re_q, do_im_q;

  assign x_re = dly_re[M-1];
  assign x_im = dly_im[M-1];

  // One guard bit keeps the full sum/difference; halving then always fits WIDTH.
  assign sum_re = {x_re[WIDTH-1], x_re} + {bus.di_re[WIDTH-1], bus.di_re};
  assign sum_im = {x_im[WIDTH-1], x_im} + {bus.di_im[WIDTH-1], bus.di_im};
  assign dif_re = {x_re[WIDTH-1], x_re} - {bus.di_re[WIDTH-1], bus.di_re};
  assign dif_im = {x_im[WIDTH-1], x_im} - {bus.di_im[WIDTH-1], bus.di_im};

  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_pend  = pend;
    shift     = 1'b0;
    emit      = 1'b0;
    drop_nxt  = 1'b0;
    addr      = '0;
    push_re   = bus.di_re;
    push_im   = bus.di_im;
    out_re    = x_re;
    out_im    = x_im;
    case (state)
      // IDLE with a start strobe behaves exactly like FILL at index 0 (cnt and pend are 0).
      IDLE, FILL: begin
        if (state == FILL || bus.di_en) begin
          shift = 1'b1;
          emit  = pend;
          addr  = cnt;
          if (cnt == LAST) begin
            nxt_state = BFLY;
            nxt_cnt   = '0;
            nxt_pend  = 1'b0;
          end else begin
            nxt_state = FILL;
            nxt_cnt   = cnt + AW'(1);
          end
        end
      end
      BFLY: begin
        shift   = 1'b1;
        emit    = 1'b1;
        out_re  = WIDTH'(sum_re >>> 1);
        out_im  = WIDTH'(sum_im >>> 1);
        push_re = WIDTH'(dif_re >>> 1);
        push_im = WIDTH'(dif_im >>> 1);
        if (cnt == LAST) begin
          nxt_pend  = 1'b1;
          nxt_cnt   = '0;
          nxt_state = bus.di_en ? FILL : DRAIN;
        end else begin
          nxt_cnt = cnt + AW'(1);
        end
      end
      default: begin
        shift    = 1'b1;
        emit     = 1'b1;
        addr     = cnt;
        push_re  = '0;
        push_im  = '0;
        drop_nxt = bus.di_en;
        if (cnt == LAST) begin
          nxt_state = IDLE;
          nxt_cnt   = '0;
          nxt_pend  = 1'b0;
        end else begin
          nxt_cnt = cnt + AW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      pend    <= 1'b0;
      do_en_q <= 1'b0;
      do_re_q <= '0;
      do_im_q <= '0;
      drop_q  <= 1'b0;
      for (int i = 0; i < M; i++) begin
        dly_re[i] <= '0;
        dly_im[i] <= '0;
      end
    end else begin
      state   <= nxt_state;
      cnt     <= nxt_cnt;
      pend    <= nxt_pend;
      do_en_q <= emit;
      do_re_q <= emit ? out_re : '0;
      do_im_q <= emit ? out_im : '0;
      drop_q  <= drop_nxt;
      if (shift) begin
        dly_re[0] <= push_re;
        dly_im[0] <= push_im;
        for (int i = 1; i < M; i++) begin
          dly_re[i] <= dly_re[i-1];
          dly_im[i] <= dly_im[i-1];
        end
      end
    end
  end

  // ROM data already lags tw_addr by one cycle, matching the registered data path.
  assign bus.tw_addr  = addr;
  assign bus.do_en    = do_en_q;
  assign bus.do_re    = do_re_q;
  assign bus.do_im    = do_im_q;
  assign bus.do_tw_re = do_en_q ? bus.tw_re : '0;
  assign bus.do_tw_im = do_en_q ? bus.tw_im : '0;
  assign bus.drop     = drop_q;
endmodule
